// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory loader: loader state
// encoding and the instruction-memory geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic [1:0] {
      ST_HDR   = 2'd0,
      ST_BYTES = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int IMEM_DEPTH     = 64;
   localparam int IMEM_ADDR_W    = 6;
   localparam int IMEM_DATA_W    = 32;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   rx_valid  : producer has a byte on rx_data
//   rx_data   : stream byte
//   rx_ready  : loader accepts a byte this cycle
//   mem_we    : write strobe, one cycle per word
//   mem_waddr : word address of the write
//   mem_wdata : assembled little-endian instruction word
// master = loader side, slave = producer / memory side.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) ();

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_waddr,
      output mem_wdata
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_waddr,
      input  mem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles accepted stream bytes into little-endian words. Byte k of a word
// lands in bits [8k+7:8k]; on the last byte the completed word is copied to
// the output register and word_valid pulses for exactly one cycle.
//   clk        : system clock
//   clear      : synchronous clear of byte index, partial word and outputs
//   byte_valid : a byte is transferred this cycle
//   byte_data  : the byte being transferred
//   word_valid : registered one-cycle pulse, word holds a complete word
//   word       : last completed word
// ---------------------------------------------------------------------------
module byte_packer
   import imem_pkg::*;
(
   input  logic                          clk,
   input  logic                          clear,
   input  logic                          byte_valid,
   input  logic [7:0]                    byte_data,
   output logic                          word_valid,
   output logic [BYTES_PER_WORD*8-1:0]   word
);

   localparam int WORD_W = BYTES_PER_WORD * 8;
   localparam int IDX_W  = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0]  byte_idx;
   logic [WORD_W-1:0] assemble;

   // The completed word is copied out separately so that a byte accepted in
   // the write cycle can start the next word without disturbing mem_wdata.
   always_ff @(posedge clk) begin
      if (clear) begin
         byte_idx   <= '0;
         assemble   <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (byte_valid) begin
            assemble[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + IDX_W'(1);
            if (byte_idx == LAST_IDX) begin
               word_valid <= 1'b1;
               word       <= {byte_data, assemble[WORD_W-9:0]};
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Takes a header byte (word count N,
// 0 meaning DEPTH) followed by 4*N bytes, writes each assembled word to the
// instruction memory and holds the pipeline until the last write has issued.
// A start pulse in DONE re-arms the loader for a new image.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   start     : one-cycle re-arm pulse, honoured only in DONE
//   bus       : stream handshake + memory write port (master modport)
//   cpu_hold  : pipeline stall while loading
//   load_done : image fully written
// ---------------------------------------------------------------------------
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_hold,
   output logic          load_done
);

   localparam logic [7:0] FULL_LAST = 8'(DEPTH - 1);

   state_t                            state;
   logic                              rx_ready_q;
   logic [7:0]                        last_idx;
   logic [7:0]                        word_idx;
   logic                              packer_clear;
   logic                              byte_valid;
   logic                              word_valid;
   logic [BYTES_PER_WORD*8-1:0]       word;

   // Only bytes arriving in BYTES are payload; the header byte is consumed
   // by the FSM directly.
   assign packer_clear = rst || ((state == ST_DONE) && start);
   assign byte_valid   = bus.rx_valid && rx_ready_q && (state == ST_BYTES);

   byte_packer u_packer (
      .clk        (clk),
      .clear      (packer_clear),
      .byte_valid (byte_valid),
      .byte_data  (bus.rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // The packer's registered pulse is the write strobe, so the write lands
   // in the cycle right after the fourth byte and mem_waddr (the current
   // word index) is already aligned with it.
   assign bus.rx_ready  = rx_ready_q;
   assign bus.mem_we    = word_valid;
   assign bus.mem_waddr = word_idx[ADDR_W-1:0];
   assign bus.mem_wdata = DATA_W'(word);

   // The header is stored as the index of the last word, so a header of 0
   // naturally becomes DEPTH-1. The word index is left on the last address
   // after the final write rather than stepping past it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_HDR;
         rx_ready_q <= 1'b1;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         last_idx   <= '0;
         word_idx   <= '0;
      end else begin
         case (state)
            ST_HDR: begin
               if (bus.rx_valid && rx_ready_q) begin
                  last_idx <= (bus.rx_data == 8'd0) ? FULL_LAST : bus.rx_data - 8'd1;
                  word_idx <= '0;
                  state    <= ST_BYTES;
               end
            end
            ST_BYTES: begin
               if (word_valid) begin
                  if (word_idx == last_idx) begin
                     state      <= ST_DONE;
                     rx_ready_q <= 1'b0;
                     cpu_hold   <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     word_idx <= word_idx + 8'd1;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state      <= ST_HDR;
                  rx_ready_q <= 1'b1;
                  cpu_hold   <= 1'b1;
                  load_done  <= 1'b0;
                  word_idx   <= '0;
               end
            end
            default: begin
               state      <= ST_HDR;
               rx_ready_q <= 1'b1;
               cpu_hold   <= 1'b1;
               load_done  <= 1'b0;
               word_idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs are driven on the
// falling edge, outputs are sampled on the falling edge; a monitor records
// every memory write (cycle, address, data).
// ---------------------------------------------------------------------------
module tb_imem_loader;
   import imem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic cpu_hold;
   logic load_done;

   imem_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   imem_loader #(.DEPTH(64), .ADDR_W(6), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (bus.master),
      .cpu_hold  (cpu_hold),
      .load_done (load_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          weCyc[$];
   logic [5:0]  weAddr[$];
   logic [31:0] weData[$];
   int          accEdge[$];
   logic [7:0]  image[$];
   logic        prevWe = 1'b0;
   int          doneCyc;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // cyc = number of rising edges so far; at a falling edge it names the
   // edge that produced the currently visible register values.
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         weCyc.push_back(cyc);
         weAddr.push_back(bus.mem_waddr);
         weData.push_back(bus.mem_wdata);
      end
      if (prevWe && bus.mem_we === 1'b1) checkOutput("we_back_to_back", 32'd1, 32'd0);
      prevWe = (bus.mem_we === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clearLog();
      weCyc.delete();
      weAddr.delete();
      weData.delete();
      accEdge.delete();
   endtask

   // Called on a falling edge; returns on the falling edge after the byte
   // transferred. rx_valid is left high so consecutive calls are back-to-back.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int tmo;
      for (int g = 0; g < gap; g++) begin
         bus.rx_valid = 1'b0;
         @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tmo = 0;
      while (bus.rx_ready !== 1'b1 && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 50) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
      else accEdge.push_back(cyc + 1);
      @(negedge clk);
   endtask

   task automatic loadImage(input logic [7:0] hdr, input bit randomGaps);
      applyStimulus(hdr, 0);
      accEdge.delete();
      foreach (image[i]) applyStimulus(image[i], randomGaps ? int'($urandom_range(0, 5)) : 0);
      bus.rx_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int tmo = 0;
      while (load_done !== 1'b1 && tmo < 2000) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 2000) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
      doneCyc = cyc;
      checkOutput({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
      checkOutput({tag, "_rx_ready_done"}, 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
   endtask

   task automatic pulseStart(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      checkOutput({tag, "_done"}, 32'(load_done), 32'd0);
      checkOutput({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
      checkOutput({tag, "_waddr"}, 32'(bus.mem_waddr), 32'd0);
   endtask

   task automatic fullImageCheck(input string tag);
      logic [31:0] exp;
      checkOutput({tag, "_write_count"}, 32'(weAddr.size()), 32'd64);
      for (int w = 0; w < 64 && w < weAddr.size(); w++) begin
         exp = {image[4*w+3], image[4*w+2], image[4*w+1], image[4*w]};
         checkOutput($sformatf("%s_addr%0d", tag, w), 32'(weAddr[w]), 32'(w));
         checkOutput($sformatf("%s_data%0d", tag, w), weData[w], exp);
      end
      if (weCyc.size() > 0)
         checkOutput({tag, "_done_after_last"}, 32'(doneCyc), 32'(weCyc[weCyc.size()-1] + 1));
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
      checkOutput("rst_done", 32'(load_done), 32'd0);
      checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_waddr", 32'(bus.mem_waddr), 32'd0);
      checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
      checkOutput("rst_ready", 32'(bus.rx_ready), 32'd1);

      // Two-word image, bytes back-to-back
      clearLog();
      image = '{8'h93, 8'h00, 8'h30, 8'h00, 8'h13, 8'hA1, 8'hC0, 8'hFF};
      loadImage(8'h02, 1'b0);
      waitDone("t1");
      checkOutput("t1_count", 32'(weAddr.size()), 32'd2);
      if (weAddr.size() == 2) begin
         checkOutput("t1_addr0", 32'(weAddr[0]), 32'd0);
         checkOutput("t1_data0", weData[0], 32'h0030_0093);
         checkOutput("t1_addr1", 32'(weAddr[1]), 32'd1);
         checkOutput("t1_data1", weData[1], 32'hFFC0_A113);
         checkOutput("t1_we_latency", 32'(weCyc[0]), 32'(accEdge[3]));
         checkOutput("t1_b2b_accept", 32'(accEdge[4]), 32'(weCyc[0] + 1));
         checkOutput("t1_hold_gap", 32'(doneCyc), 32'(weCyc[1] + 1));
      end

      // Full 64-word image (header 0), back-to-back
      pulseStart("t2_start");
      clearLog();
      image.delete();
      for (int j = 0; j < 256; j++) image.push_back(8'(j * 37 + 5));
      loadImage(8'h00, 1'b0);
      waitDone("t2");
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hAA;
      repeat (8) @(negedge clk);
      bus.rx_valid = 1'b0;
      checkOutput("t2_extra_ready", 32'(bus.rx_ready), 32'd0);
      fullImageCheck("t2");

      // Same image with random gaps
      pulseStart("t3_start");
      clearLog();
      loadImage(8'h00, 1'b1);
      waitDone("t3");
      fullImageCheck("t3");

      // Reset in the middle of word 1
      pulseStart("t4_start");
      clearLog();
      applyStimulus(8'h03, 0);
      for (int j = 0; j < 6; j++) applyStimulus(8'(8'h50 + j), 0);
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t4_writes_before_rst", 32'(weAddr.size()), 32'd1);
      checkOutput("t4_hold", 32'(cpu_hold), 32'd1);
      checkOutput("t4_done", 32'(load_done), 32'd0);
      checkOutput("t4_ready", 32'(bus.rx_ready), 32'd1);
      checkOutput("t4_waddr", 32'(bus.mem_waddr), 32'd0);
      clearLog();
      image = '{8'h33, 8'h00, 8'h00, 8'h00};
      loadImage(8'h01, 1'b0);
      waitDone("t4");
      checkOutput("t4_count", 32'(weAddr.size()), 32'd1);
      if (weAddr.size() == 1) begin
         checkOutput("t4_addr", 32'(weAddr[0]), 32'd0);
         checkOutput("t4_data", weData[0], 32'h0000_0033);
      end

      // Re-arm and load one word
      pulseStart("t5_start");
      clearLog();
      image = '{8'h13, 8'hD5, 8'h20, 8'h40};
      loadImage(8'h01, 1'b0);
      waitDone("t5");
      checkOutput("t5_count", 32'(weAddr.size()), 32'd1);
      if (weAddr.size() == 1) begin
         checkOutput("t5_addr", 32'(weAddr[0]), 32'd0);
         checkOutput("t5_data", weData[0], 32'h4020_D513);
      end

      // Start pulse while in BYTES must be ignored
      pulseStart("t6_start");
      clearLog();
      applyStimulus(8'h02, 0);
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 0);
      bus.rx_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("t6_hold_in_bytes", 32'(cpu_hold), 32'd1);
      image = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      foreach (image[i]) applyStimulus(image[i], 1);
      bus.rx_valid = 1'b0;
      waitDone("t6");
      checkOutput("t6_count", 32'(weAddr.size()), 32'd2);
      if (weAddr.size() == 2) begin
         checkOutput("t6_addr0", 32'(weAddr[0]), 32'd0);
         checkOutput("t6_data0", weData[0], 32'h4433_2211);
         checkOutput("t6_addr1", 32'(weAddr[1]), 32'd1);
         checkOutput("t6_data1", weData[1], 32'h8877_6655);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
